// File: rtl/icache_nway.sv
`default_nettype none
// ============================================================================
// Module      : icache_nway
// Description : Set-associative instruction cache with true-LRU replacement,
//               single-outstanding miss FSM, flush and hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_nway #(
    parameter int NUM_SETS       = 16,
    parameter int NUM_WAYS       = 4,
    parameter int WORDS_PER_LINE = 16,
    parameter int CNT_W          = 32
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [31:0]                   pc_i,
    input  logic                          pc_valid_i,
    input  logic                          flush_i,
    output logic [31:0]                   instr_o,
    output logic                          valid_o,
    output logic                          busy_o,
    output logic                          mem_req_valid_o,
    input  logic                          mem_req_ready_i,
    output logic [31:0]                   mem_req_addr_o,
    input  logic                          mem_rsp_valid_i,
    output logic                          mem_rsp_ready_o,
    input  logic [31:0]                   mem_rsp_addr_i,
    input  logic [32*WORDS_PER_LINE-1:0]  mem_rsp_line_i,
    output logic [CNT_W-1:0]              hit_cnt_o,
    output logic [CNT_W-1:0]              miss_cnt_o
);

    localparam int c_wsel_w = $clog2(WORDS_PER_LINE);
    localparam int c_off    = 2 + c_wsel_w;
    localparam int c_idx_w  = $clog2(NUM_SETS);
    localparam int c_tag_w  = 32 - c_off - c_idx_w;
    localparam int c_way_w  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int c_line_w = 32 * WORDS_PER_LINE;
    localparam logic [31:0]        c_nop     = 32'h0000_0013;
    localparam logic [c_way_w-1:0] c_max_age = c_way_w'(NUM_WAYS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_drop;
    logic   w_drop_nxt;
    logic [31:0] r_req_addr;
    logic [31:0] w_req_addr_nxt;

    logic [c_tag_w-1:0]  r_tag   [NUM_SETS][NUM_WAYS];
    logic [c_line_w-1:0] r_data  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
    logic [c_way_w-1:0]  r_age   [NUM_SETS][NUM_WAYS];
    logic [c_way_w-1:0]  w_age_nxt [NUM_SETS][NUM_WAYS];

    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    logic [c_idx_w-1:0]  w_idx;
    logic [c_tag_w-1:0]  w_tag;
    logic [c_wsel_w-1:0] w_wsel;
    logic [c_idx_w-1:0]  w_req_idx;
    logic [c_tag_w-1:0]  w_req_tag;
    logic                w_hit_any;
    logic [c_way_w-1:0]  w_hit_way;
    logic                w_hit;
    logic [c_line_w-1:0] w_line_sel;
    logic [31:0]         w_word;
    logic                w_inv_any;
    logic [c_way_w-1:0]  w_inv_way;
    logic [c_way_w-1:0]  w_lru_way;
    logic [c_way_w-1:0]  w_victim;
    logic [c_way_w-1:0]  w_hit_old_age;
    logic [c_way_w-1:0]  w_vic_old_age;
    logic                w_rsp_match;
    logic                w_fill;
    logic                w_miss_issue;
    logic                w_unused;

    assign w_idx     = pc_i[c_off +: c_idx_w];
    assign w_tag     = pc_i[31 -: c_tag_w];
    assign w_wsel    = pc_i[2 +: c_wsel_w];
    assign w_req_idx = r_req_addr[c_off +: c_idx_w];
    assign w_req_tag = r_req_addr[31 -: c_tag_w];
    assign w_unused  = ^pc_i[1:0];

    always_comb begin
        w_hit_any = 1'b0;
        w_hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit_any = 1'b1;
                w_hit_way = c_way_w'(w);
            end
        end
    end

    assign w_hit      = pc_valid_i && !flush_i && w_hit_any;
    assign w_line_sel = r_data[w_idx][w_hit_way];
    assign w_word     = w_line_sel[32*w_wsel +: 32];

    // Invalid ways are preferred over the oldest valid way when choosing a victim.
    always_comb begin
        w_inv_any = 1'b0;
        w_inv_way = '0;
        w_lru_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_req_idx][w]) begin
                w_inv_any = 1'b1;
                w_inv_way = c_way_w'(w);
            end
            if (r_age[w_req_idx][w] == c_max_age) begin
                w_lru_way = c_way_w'(w);
            end
        end
    end

    assign w_victim      = w_inv_any ? w_inv_way : w_lru_way;
    assign w_hit_old_age = r_age[w_idx][w_hit_way];
    assign w_vic_old_age = r_age[w_req_idx][w_victim];

    assign w_rsp_match  = (r_state == ST_WAIT) && mem_rsp_valid_i && (mem_rsp_addr_i == r_req_addr);
    assign w_fill       = w_rsp_match && !r_drop && !flush_i;
    assign w_miss_issue = (r_state == ST_IDLE) && pc_valid_i && !flush_i && !w_hit_any;

    // A fill rewrites its whole set's ages afterwards, so it overrides a same-set hit.
    always_comb begin
        w_age_nxt = r_age;
        if (flush_i) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    w_age_nxt[s][w] = c_way_w'(w);
                end
            end
        end else begin
            if (w_hit) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (c_way_w'(w) == w_hit_way) begin
                        w_age_nxt[w_idx][w] = '0;
                    end else if (r_age[w_idx][w] < w_hit_old_age) begin
                        w_age_nxt[w_idx][w] = r_age[w_idx][w] + 1'b1;
                    end
                end
            end
            if (w_fill) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (c_way_w'(w) == w_victim) begin
                        w_age_nxt[w_req_idx][w] = '0;
                    end else if (r_age[w_req_idx][w] < w_vic_old_age) begin
                        w_age_nxt[w_req_idx][w] = r_age[w_req_idx][w] + 1'b1;
                    end else begin
                        w_age_nxt[w_req_idx][w] = r_age[w_req_idx][w];
                    end
                end
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_drop_nxt     = r_drop;
        w_req_addr_nxt = r_req_addr;
        case (r_state)
            ST_IDLE: begin
                if (w_miss_issue) begin
                    w_req_addr_nxt = {pc_i[31:c_off], {c_off{1'b0}}};
                    w_state_nxt    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush_i) begin
                    w_drop_nxt = 1'b1;
                end
                if (mem_req_ready_i) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_rsp_match) begin
                    w_state_nxt = ST_IDLE;
                    w_drop_nxt  = 1'b0;
                end else if (flush_i) begin
                    w_drop_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_drop_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= ST_IDLE;
            r_drop     <= 1'b0;
            r_req_addr <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_age[s][w] <= c_way_w'(w);
                end
            end
        end else begin
            r_state    <= w_state_nxt;
            r_drop     <= w_drop_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_age      <= w_age_nxt;
            if (flush_i) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    r_valid[s] <= '0;
                end
            end else if (w_fill) begin
                r_valid[w_req_idx][w_victim] <= 1'b1;
            end
            if (w_hit && (r_hit_cnt != {CNT_W{1'b1}})) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (w_miss_issue && (r_miss_cnt != {CNT_W{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    // Tag and data arrays are qualified by the valid bits and need no reset.
    always_ff @(posedge clk_i) begin
        if (w_fill) begin
            r_tag[w_req_idx][w_victim]  <= w_req_tag;
            r_data[w_req_idx][w_victim] <= mem_rsp_line_i;
        end
    end

    assign valid_o         = w_hit;
    assign instr_o         = w_hit ? w_word : c_nop;
    assign busy_o          = (r_state != ST_IDLE);
    assign mem_req_valid_o = (r_state == ST_REQ);
    assign mem_req_addr_o  = r_req_addr;
    assign mem_rsp_ready_o = 1'b1;
    assign hit_cnt_o       = r_hit_cnt;
    assign miss_cnt_o      = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_icache_nway.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_nway
// Description : Directed and randomized bench for icache_nway against an
//               LRU-list reference model of the cache and miss handling.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_nway;

    localparam int NS  = 16;
    localparam int NW  = 4;
    localparam int WPL = 16;
    localparam int CW  = 4;
    localparam int OFF = 2 + $clog2(WPL);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk_i = 1'b0;
    logic rstn_i;
    logic [31:0] pc_i;
    logic pc_valid_i;
    logic flush_i;
    logic [31:0] instr_o;
    logic valid_o;
    logic busy_o;
    logic mem_req_valid_o;
    logic mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic mem_rsp_valid_i;
    logic mem_rsp_ready_o;
    logic [31:0] mem_rsp_addr_i;
    logic [32*WPL-1:0] mem_rsp_line_i;
    logic [CW-1:0] hit_cnt_o;
    logic [CW-1:0] miss_cnt_o;

    icache_nway #(.NUM_SETS(NS), .NUM_WAYS(NW), .WORDS_PER_LINE(WPL), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
        .flush_i(flush_i), .instr_o(instr_o), .valid_o(valid_o), .busy_o(busy_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_ready_o(mem_rsp_ready_o), .mem_rsp_addr_i(mem_rsp_addr_i),
        .mem_rsp_line_i(mem_rsp_line_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-set list of resident line addresses, most recent first.
    logic [31:0] m_lines [NS][$];
    int          m_phase;
    logic [31:0] m_req;
    bit          m_drop;
    int          m_hit_cnt;
    int          m_miss_cnt;
    bit          cur_hit;

    bit          pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          rsp_delay;
    bit          foreign_en;
    int          dut_hs;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return {a[31:OFF], {OFF{1'b0}}};
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> OFF) & (NS - 1));
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] l, input int k);
        logic [31:0] kk;
        kk = 32'(k);
        if (l == 32'h40 && k < 2) return 32'hDEAD_BEEF;
        return (l * 32'h9E37_79B1) ^ (kk * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [32*WPL-1:0] line_data(input logic [31:0] l);
        logic [32*WPL-1:0] d;
        for (int k = 0; k < WPL; k++) d[32*k +: 32] = mem_word(l, k);
        return d;
    endfunction

    function automatic bit model_has(input logic [31:0] l);
        int s;
        s = set_of(l);
        for (int i = 0; i < m_lines[s].size(); i++) if (m_lines[s][i] == l) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input bit keep_pend);
        for (int s = 0; s < NS; s++) m_lines[s].delete();
        m_phase = 0; m_req = '0; m_drop = 1'b0; m_hit_cnt = 0; m_miss_cnt = 0;
        if (!keep_pend) pend = 1'b0;
    endtask

    task automatic tick_pre();
        logic [31:0] l;
        mem_rsp_valid_i = 1'b0; mem_rsp_addr_i = '0; mem_rsp_line_i = '0;
        if (pend) begin
            if (pend_cnt == 0) begin
                mem_rsp_valid_i = 1'b1; mem_rsp_addr_i = pend_addr;
                mem_rsp_line_i = line_data(pend_addr); pend = 1'b0;
            end else begin
                pend_cnt--;
                if (foreign_en) begin
                    mem_rsp_valid_i = 1'b1; mem_rsp_addr_i = pend_addr ^ 32'h0000_00C0;
                    mem_rsp_line_i = line_data(pend_addr ^ 32'h0000_00C0);
                end
            end
        end
        #1;
        l = line_of(pc_i);
        cur_hit = pc_valid_i && !flush_i && model_has(l);
        chk("valid_o", 32'(valid_o), 32'(cur_hit));
        chk("instr_o", instr_o, cur_hit ? mem_word(l, int'(pc_i[OFF-1:2])) : NOP);
        chk("busy_o", 32'(busy_o), 32'(m_phase != 0));
        chk("mem_req_valid_o", 32'(mem_req_valid_o), 32'(m_phase == 1));
        if (m_phase == 1) chk("mem_req_addr_o", mem_req_addr_o, m_req);
        chk("hit_cnt_o", 32'(hit_cnt_o), 32'(m_hit_cnt));
        chk("miss_cnt_o", 32'(miss_cnt_o), 32'(m_miss_cnt));
        if (mem_req_valid_o && mem_req_ready_i) dut_hs++;
    endtask

    task automatic tick_post();
        logic [31:0] pl;
        int ps, fs, idx;
        bit fill;
        pl = line_of(pc_i);
        ps = set_of(pc_i);
        fs = set_of(m_req);
        fill = (m_phase == 2) && mem_rsp_valid_i && (mem_rsp_addr_i == m_req) && !m_drop && !flush_i;
        if (cur_hit && !(fill && fs == ps)) begin
            idx = -1;
            for (int i = 0; i < m_lines[ps].size(); i++) if (m_lines[ps][i] == pl) idx = i;
            m_lines[ps].delete(idx);
            m_lines[ps].push_front(pl);
        end
        if (fill) begin
            m_lines[fs].push_front(m_req);
            if (m_lines[fs].size() > NW) void'(m_lines[fs].pop_back());
        end
        if (flush_i) for (int s = 0; s < NS; s++) m_lines[s].delete();
        if (cur_hit && m_hit_cnt < (1 << CW) - 1) m_hit_cnt++;
        case (m_phase)
            0: if (pc_valid_i && !flush_i && !cur_hit) begin
                m_req = pl; m_phase = 1;
                if (m_miss_cnt < (1 << CW) - 1) m_miss_cnt++;
            end
            1: begin
                if (flush_i) m_drop = 1'b1;
                if (mem_req_ready_i) begin
                    m_phase = 2; pend = 1'b1; pend_addr = m_req;
                    pend_cnt = (rsp_delay < 0) ? int'($urandom_range(0, 3)) : rsp_delay;
                end
            end
            default: if (mem_rsp_valid_i && mem_rsp_addr_i == m_req) begin
                m_phase = 0; m_drop = 1'b0;
            end else if (flush_i) m_drop = 1'b1;
        endcase
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic cycle();
        tick_pre();
        tick_post();
    endtask

    task automatic do_reset();
        rstn_i = 1'b0; pc_valid_i = 1'b0; flush_i = 1'b0; pc_i = '0;
        mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_addr_i = '0; mem_rsp_line_i = '0;
        foreign_en = 1'b0; rsp_delay = 1; dut_hs = 0;
        model_reset(1'b0);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic drain();
        pc_valid_i = 1'b0; flush_i = 1'b0; mem_req_ready_i = 1'b1;
        for (int i = 0; i < 40 && (m_phase != 0 || pend); i++) cycle();
        #1 chk("drain_idle", 32'(busy_o), 32'd0);
    endtask

    task automatic fetch(input logic [31:0] pc, input string tag);
        bit got;
        pc_i = pc; pc_valid_i = 1'b1; flush_i = 1'b0; mem_req_ready_i = 1'b1; got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick_pre();
            got = valid_o;
            tick_post();
        end
        chk(tag, 32'(got), 32'd1);
        drain();
    endtask

    task automatic probe(input logic [31:0] pc, input bit exp_hit, input string tag);
        pc_i = pc; pc_valid_i = 1'b1; flush_i = 1'b0;
        tick_pre();
        chk(tag, 32'(valid_o), 32'(exp_hit));
        tick_post();
        pc_valid_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pend = 1'b0;
        do_reset();
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_instr", instr_o, NOP);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
        chk("rst_req_addr", mem_req_addr_o, 32'd0);
        chk("rst_rsp_ready", 32'(mem_rsp_ready_o), 32'd1);
        chk("rst_cnts", 32'({hit_cnt_o, miss_cnt_o}), 32'd0);
        @(negedge clk_i);

        // Cold miss: request one cycle later, data valid four cycles after the miss.
        pc_i = 32'h40; pc_valid_i = 1'b1;
        tick_pre(); chk("cold_c0_valid", 32'(valid_o), 32'd0); tick_post();
        tick_pre(); chk("cold_req_valid", 32'(mem_req_valid_o), 32'd1);
        chk("cold_req_addr", mem_req_addr_o, 32'h40); tick_post();
        cycle();
        cycle();
        tick_pre(); chk("cold_c4_valid", 32'(valid_o), 32'd1);
        chk("cold_c4_instr", instr_o, 32'hDEAD_BEEF);
        chk("cold_miss_cnt", 32'(miss_cnt_o), 32'd1); tick_post();
        drain();

        // LRU replacement in set 0
        do_reset();
        fetch(32'h000, "lru_fill0"); fetch(32'h400, "lru_fill1");
        fetch(32'h800, "lru_fill2"); fetch(32'hC00, "lru_fill3");
        probe(32'h000, 1'b1, "lru_rehit");
        fetch(32'h1000, "lru_fill4");
        probe(32'h000, 1'b1, "lru_keep0");
        probe(32'h800, 1'b1, "lru_keep8");
        probe(32'hC00, 1'b1, "lru_keepC");
        probe(32'h1000, 1'b1, "lru_new");
        probe(32'h400, 1'b0, "lru_victim");
        drain();

        // Request backpressure
        do_reset();
        mem_req_ready_i = 1'b0; pc_i = 32'h40; pc_valid_i = 1'b1;
        cycle();
        pc_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick_pre();
            chk("bp_req_valid", 32'(mem_req_valid_o), 32'd1);
            chk("bp_req_addr", mem_req_addr_o, 32'h40);
            tick_post();
        end
        drain();
        chk("bp_one_req", 32'(dut_hs), 32'd1);
        chk("bp_miss_cnt", 32'(miss_cnt_o), 32'd1);
        @(negedge clk_i);

        // Foreign response while waiting
        do_reset();
        rsp_delay = 2; foreign_en = 1'b1; pc_i = 32'h40; pc_valid_i = 1'b1;
        cycle();
        pc_valid_i = 1'b0;
        cycle();
        cycle();
        tick_pre(); chk("foreign_busy", 32'(busy_o), 32'd1);
        chk("foreign_no_req", 32'(mem_req_valid_o), 32'd0); tick_post();
        cycle();
        foreign_en = 1'b0;
        probe(32'h40, 1'b1, "foreign_fill");
        probe(32'h80, 1'b0, "foreign_nofill");
        drain();

        // Flush during WAIT
        do_reset();
        fetch(32'h40, "fl_fill40"); fetch(32'h400, "fl_fill400");
        rsp_delay = 3; pc_i = 32'h800; pc_valid_i = 1'b1;
        cycle();
        pc_valid_i = 1'b0;
        cycle();
        pc_i = 32'h40; pc_valid_i = 1'b1; flush_i = 1'b1;
        tick_pre(); chk("flush_forces_miss", 32'(valid_o), 32'd0); tick_post();
        drain();
        probe(32'h40, 1'b0, "flush_40_gone"); drain();
        probe(32'h400, 1'b0, "flush_400_gone"); drain();
        probe(32'h800, 1'b0, "flush_800_dropped"); drain();
        chk("flush_miss_cnt", 32'(miss_cnt_o), 32'd6);
        @(negedge clk_i);

        // Hit-under-miss and hit counter saturation
        do_reset();
        fetch(32'h40, "hum_fill");
        rsp_delay = 3; pc_i = 32'h400; pc_valid_i = 1'b1;
        cycle();
        pc_i = 32'h40;
        for (int i = 0; i < 20; i++) begin
            tick_pre();
            chk("hum_valid", 32'(valid_o), 32'd1);
            chk("hum_no_new_miss", 32'(miss_cnt_o), 32'd2);
            tick_post();
        end
        #1 chk("hit_cnt_sat", 32'(hit_cnt_o), 32'hF);
        drain();

        // Asynchronous reset mid-miss, stale response ignored
        do_reset();
        rsp_delay = 3; pc_i = 32'h40; pc_valid_i = 1'b1;
        cycle();
        pc_valid_i = 1'b0;
        cycle();
        cycle();
        #2 rstn_i = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_req_valid", 32'(mem_req_valid_o), 32'd0);
        chk("arst_miss_cnt", 32'(miss_cnt_o), 32'd0);
        model_reset(1'b1);
        @(negedge clk_i);
        rstn_i = 1'b1;
        drain();
        probe(32'h40, 1'b0, "stale_ignored");
        drain();

        // Randomized traffic over two sets with six candidate tags each
        do_reset();
        rsp_delay = -1;
        for (int i = 0; i < 1500; i++) begin
            pc_i = ($urandom_range(0, 5) << 10) | ($urandom_range(0, 1) << OFF)
                 | ($urandom_range(0, WPL - 1) << 2) | $urandom_range(0, 3);
            pc_valid_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 39) == 0);
            mem_req_ready_i = $urandom_range(0, 1) != 0;
            foreign_en = ($urandom_range(0, 3) == 0);
            cycle();
        end
        foreign_en = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
